// File: rtl/sad_search_controller_pkg.sv
// Shared state encoding and width/timing constants for the SAD candidate search.
package sad_search_controller_pkg;
  localparam int DATAWIDTH_DEF   = 8;
  localparam int ROWS_DEF        = 8;
  localparam int ROW_LAST        = ROWS_DEF - 1;
  localparam int CYCLES_PER_CAND = ROWS_DEF + 3;
  localparam int SAD_W           = DATAWIDTH_DEF + 9;
  localparam int COST_W          = DATAWIDTH_DEF + 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_OUT,
    S_CAPTURE,
    S_DONE
  } state_t;
endpackage

// File: rtl/sad_search_controller_min_tracker.sv
// Running minimum of captured SAD costs; the last completed search's result is
// kept aside so an aborted search can be rolled back.
module sad_min_tracker #(
  parameter int SAD_W = 17
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_capture,
  input  logic             i_first,
  input  logic             i_abort,
  input  logic             i_commit,
  input  logic [SAD_W-1:0] i_sad,
  input  logic [3:0]       i_idx,
  output logic [SAD_W-1:0] o_best_sad,
  output logic [3:0]       o_best_idx
);
  logic [SAD_W-1:0] r_best_sad, r_saved_sad;
  logic [3:0]       r_best_idx, r_saved_idx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_best_sad  <= '0;
      r_best_idx  <= '0;
      r_saved_sad <= '0;
      r_saved_idx <= '0;
    end else if (i_abort) begin
      r_best_sad <= r_saved_sad;
      r_best_idx <= r_saved_idx;
    end else begin
      // Strict less-than keeps the lower index on ties.
      if (i_capture && (i_first || (i_sad < r_best_sad))) begin
        r_best_sad <= i_sad;
        r_best_idx <= i_idx;
      end
      if (i_commit) begin
        r_saved_sad <= r_best_sad;
        r_saved_idx <= r_best_idx;
      end
    end
  end

  assign o_best_sad = r_best_sad;
  assign o_best_idx = r_best_idx;
endmodule

// File: rtl/sad_search_controller.sv
// Steps one 8x8 SAD datapath over NUM_CAND candidates (ROWS+3 cycles each) and
// reports the minimum lambda-weighted cost and its index with a done pulse.
module sad_search_controller
  import sad_search_controller_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int NUM_CAND  = 9,
  parameter int ROWS      = ROWS_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_flush,
  input  logic [DATAWIDTH+7:0]   i_cost_in,
  input  logic [DATAWIDTH+8:0]   i_sad_in,
  output logic [3:0]             o_cand_idx,
  output logic [2:0]             o_row_idx,
  output logic                   o_sad_enable_calculation,
  output logic                   o_sad_sel,
  output logic                   o_sad_enable_out,
  output logic [DATAWIDTH+7:0]   o_sad_lambda_r,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [DATAWIDTH+8:0]   o_best_sad,
  output logic [3:0]             o_best_idx
);
  localparam int         LP_SAD_W     = DATAWIDTH + 9;
  localparam int         LP_COST_W    = DATAWIDTH + 8;
  localparam logic [2:0] LP_ROW_LAST  = 3'(ROWS - 1);
  localparam logic [3:0] LP_CAND_LAST = 4'(NUM_CAND - 1);

  state_t               r_state, w_next;
  logic [3:0]           r_cand_idx;
  logic [2:0]           r_row_idx;
  logic [LP_COST_W-1:0] r_lambda;
  logic                 r_en, r_sel;
  logic                 w_busy, w_fetch_row0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_next = S_FETCH;
      S_FETCH:   if (r_row_idx == LP_ROW_LAST) w_next = S_WAIT;
      S_WAIT:    w_next = S_OUT;
      S_OUT:     w_next = S_CAPTURE;
      S_CAPTURE: w_next = (r_cand_idx == LP_CAND_LAST) ? S_DONE : S_FETCH;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (i_flush) w_next = S_IDLE;
  end

  assign w_fetch_row0 = (r_state == S_FETCH) && (r_row_idx == 3'd0);
  assign w_busy       = (r_state != S_IDLE) && (r_state != S_DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cand_idx <= '0;
      r_row_idx  <= '0;
      r_lambda   <= '0;
      r_en       <= 1'b0;
      r_sel      <= 1'b0;
    end else begin
      r_state <= w_next;
      // Strobes trail the row address by one cycle to cover the buffer read latency.
      r_en  <= (r_state == S_FETCH) && !i_flush;
      r_sel <= w_fetch_row0 && !i_flush;
      if (w_fetch_row0 && !i_flush) r_lambda <= i_cost_in;
      if (i_flush) begin
        r_cand_idx <= '0;
        r_row_idx  <= '0;
      end else if ((r_state == S_IDLE) && i_start) begin
        r_cand_idx <= '0;
        r_row_idx  <= '0;
      end else if (r_state == S_FETCH) begin
        r_row_idx <= (r_row_idx == LP_ROW_LAST) ? 3'd0 : r_row_idx + 3'd1;
      end else if ((r_state == S_CAPTURE) && (w_next == S_FETCH)) begin
        r_cand_idx <= r_cand_idx + 4'd1;
      end
    end
  end

  sad_min_tracker #(.SAD_W(LP_SAD_W)) u_min (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_capture  ((r_state == S_CAPTURE) && !i_flush),
    .i_first    (r_cand_idx == 4'd0),
    .i_abort    (i_flush && w_busy),
    .i_commit   (r_state == S_DONE),
    .i_sad      (i_sad_in),
    .i_idx      (r_cand_idx),
    .o_best_sad (o_best_sad),
    .o_best_idx (o_best_idx)
  );

  assign o_cand_idx               = r_cand_idx;
  assign o_row_idx                = r_row_idx;
  assign o_sad_enable_calculation = r_en;
  assign o_sad_sel                = r_sel;
  assign o_sad_enable_out         = (r_state == S_OUT);
  assign o_sad_lambda_r           = r_lambda;
  assign o_busy                   = w_busy;
  assign o_done                   = (r_state == S_DONE);
endmodule

// File: tb/tb_sad_search_controller.sv
// Bench for sad_search_controller: datapath emulator, cycle-formula reference model, directed and random searches.
module tb_sad_search_controller;
  localparam int N   = 9;
  localparam int TOT = 11 * N;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [15:0] cost_in;
  logic [16:0] sad_in;
  logic [3:0]  cand_idx, best_idx;
  logic [2:0]  row_idx;
  logic        en, sel, eo, busy, done;
  logic [15:0] lam;
  logic [16:0] best_sad;

  logic [15:0] cost_tbl [16];
  logic [7:0]  diff_tbl [16];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sad_search_controller #(.DATAWIDTH(8), .NUM_CAND(N), .ROWS(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_flush(flush),
    .i_cost_in(cost_in), .i_sad_in(sad_in),
    .o_cand_idx(cand_idx), .o_row_idx(row_idx),
    .o_sad_enable_calculation(en), .o_sad_sel(sel), .o_sad_enable_out(eo),
    .o_sad_lambda_r(lam), .o_busy(busy), .o_done(done),
    .o_best_sad(best_sad), .o_best_idx(best_idx)
  );

  assign cost_in = cost_tbl[cand_idx];

  // SAD datapath stand-in: each pixel of candidate k differs by diff_tbl[k].
  logic [16:0] dp_acc, dp_out;
  logic [3:0]  dp_cand_d;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_acc <= '0; dp_out <= '0; dp_cand_d <= '0;
    end else begin
      dp_cand_d <= cand_idx;
      if (en) dp_acc <= (sel ? {1'b0, lam} : dp_acc) + (17'(diff_tbl[dp_cand_d]) << 3);
      if (eo) dp_out <= dp_acc;
    end
  end
  assign sad_in = dp_out;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] cand_cost(input int k);
    return 17'(cost_tbl[k]) + 17'(diff_tbl[k]) * 17'd64;
  endfunction

  task automatic ref_best(output logic [16:0] b, output logic [3:0] bi);
    b = '0; bi = '0;
    for (int k = 0; k < N; k++)
      if (k == 0 || cand_cost(k) < b) begin b = cand_cost(k); bi = 4'(k); end
  endtask

  // Reference model: position t within a search determines every output.
  initial begin
    bit          m_act;
    int          mt, k, p;
    logic [16:0] mbest, sbest;
    logic [3:0]  midx, sidx;
    logic [15:0] mlam;
    logic        st, fl, rn;
    m_act = 0; mt = 0; mbest = '0; sbest = '0; midx = '0; sidx = '0; mlam = '0;
    forever begin
      @(posedge clk);
      st = start; fl = flush; rn = rst_n;
      #1;
      if (!rn) begin
        m_act = 0; mbest = '0; midx = '0; sbest = '0; sidx = '0; mlam = '0;
      end else if (fl) begin
        if (m_act && mt <= TOT) begin mbest = sbest; midx = sidx; end
        if (m_act && mt == TOT + 1) begin sbest = mbest; sidx = midx; end
        m_act = 0;
      end else if (m_act) begin
        k = (mt - 1) / 11; p = (mt - 1) % 11;
        if (mt <= TOT && p == 0) mlam = cost_tbl[k];
        if (mt <= TOT && p == 10 && (k == 0 || cand_cost(k) < mbest)) begin
          mbest = cand_cost(k); midx = 4'(k);
        end
        if (mt == TOT + 1) begin sbest = mbest; sidx = midx; m_act = 0; end
        else mt++;
      end else if (st) begin
        m_act = 1; mt = 1;
      end

      if (!rst_n) begin
        chk("rst_cand", cand_idx, 0); chk("rst_row", row_idx, 0);
        chk("rst_en", en, 0); chk("rst_sel", sel, 0); chk("rst_eo", eo, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0);
      end else if (m_act && mt <= TOT) begin
        k = (mt - 1) / 11; p = (mt - 1) % 11;
        chk("cyc_cand", cand_idx, k);
        chk("cyc_row", row_idx, (p <= 7) ? p : 0);
        chk("cyc_en", en, (p >= 1 && p <= 8));
        chk("cyc_sel", sel, (p == 1));
        chk("cyc_eo", eo, (p == 9));
        chk("cyc_busy", busy, 1);
        chk("cyc_done", done, 0);
      end else if (m_act) begin
        chk("done_cand", cand_idx, N - 1);
        chk("done_pulse", done, 1); chk("done_busy", busy, 0);
        chk("done_en", en, 0); chk("done_eo", eo, 0);
      end else begin
        chk("idle_en", en, 0); chk("idle_sel", sel, 0); chk("idle_eo", eo, 0);
        chk("idle_busy", busy, 0); chk("idle_done", done, 0);
      end
      chk("cyc_lambda", lam, mlam);
      chk("cyc_best_sad", best_sad, mbest);
      chk("cyc_best_idx", best_idx, midx);
    end
  end

  // One search: start at cycle 0, optional extra starts, flush or reset at given cycles.
  task automatic run_search(input int flush_at, input int rst_at, input int sa, input int sb,
                            output int done_at, output int ndone,
                            output int n_en, output int n_sel, output int n_eo);
    done_at = -1; ndone = 0; n_en = 0; n_sel = 0; n_eo = 0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 115; n++) begin
      @(negedge clk);
      start = (n == sa) || (n == sb);
      flush = (n == flush_at);
      if (rst_at > 0 && n == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst_cand", cand_idx, 0); chk("async_rst_en", en, 0);
        chk("async_rst_busy", busy, 0); chk("async_rst_lambda", lam, 0);
        chk("async_rst_best_sad", best_sad, 0); chk("async_rst_best_idx", best_idx, 0);
      end
      if (rst_at > 0 && n == rst_at + 2) rst_n = 1'b1;
      if (flush_at > 0 && n == flush_at + 1) chk("flush_busy_drop", busy, 0);
      if (done) begin ndone++; if (done_at < 0) done_at = n; end
      n_en  += int'(en);
      n_sel += int'(sel);
      n_eo  += int'(eo);
    end
    start = 1'b0; flush = 1'b0;
  endtask

  initial begin
    int d, nd, ne, ns, no, fa;
    logic [16:0] eb;
    logic [3:0]  ei;
    int t1c [9] = '{50, 40, 30, 20, 10, 20, 30, 40, 50};
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    for (int i = 0; i < 16; i++) begin cost_tbl[i] = '0; diff_tbl[i] = '0; end
    repeat (3) @(negedge clk);
    chk("reset_best_sad", best_sad, 0); chk("reset_best_idx", best_idx, 0);
    chk("reset_lambda", lam, 0); chk("reset_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < N; i++) cost_tbl[i] = 16'(t1c[i]);
    run_search(-1, -1, -1, -1, d, nd, ne, ns, no);
    chk("t1_done_cycle", d, 100); chk("t1_done_count", nd, 1);
    chk("t1_best_sad", best_sad, 10); chk("t1_best_idx", best_idx, 4);

    for (int i = 0; i < N; i++) cost_tbl[i] = 16'd100;
    run_search(-1, -1, 5, 100, d, nd, ne, ns, no);
    chk("t2_done_cycle", d, 100); chk("t2_done_count", nd, 1);
    chk("t2_enables", ne, 72); chk("t2_sels", ns, 9); chk("t2_enable_outs", no, 9);
    chk("t2_best_sad", best_sad, 100); chk("t2_best_idx", best_idx, 0);

    for (int i = 0; i < N; i++) begin cost_tbl[i] = '0; diff_tbl[i] = 8'd3; end
    diff_tbl[7] = 8'd1;
    run_search(-1, -1, -1, -1, d, nd, ne, ns, no);
    chk("t3_best_sad", best_sad, 64); chk("t3_best_idx", best_idx, 7);

    for (int i = 0; i < N; i++) begin cost_tbl[i] = 16'd5; diff_tbl[i] = '0; end
    run_search(40, -1, -1, -1, d, nd, ne, ns, no);
    chk("t5_no_done", nd, 0);
    chk("t5_kept_sad", best_sad, 64); chk("t5_kept_idx", best_idx, 7);
    run_search(-1, -1, -1, -1, d, nd, ne, ns, no);
    chk("t5_restart_cycle", d, 100);
    chk("t5_restart_sad", best_sad, 5); chk("t5_restart_idx", best_idx, 0);

    for (int i = 0; i < N; i++) begin
      cost_tbl[i] = 16'($urandom_range(0, 500)); diff_tbl[i] = 8'($urandom_range(0, 20));
    end
    run_search(-1, 57, -1, -1, d, nd, ne, ns, no);
    chk("t6_no_done", nd, 0);
    run_search(-1, -1, -1, -1, d, nd, ne, ns, no);
    ref_best(eb, ei);
    chk("t6_done_cycle", d, 100);
    chk("t6_best_sad", best_sad, eb); chk("t6_best_idx", best_idx, ei);

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N; i++) begin
        cost_tbl[i] = 16'($urandom_range(0, 3) * 10);
        diff_tbl[i] = 8'($urandom_range(0, 2));
      end
      fa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 99)) : -1;
      run_search(fa, -1, -1, -1, d, nd, ne, ns, no);
      chk("rand_done_count", nd, (fa < 0) ? 1 : 0);
      if (fa < 0) begin
        ref_best(eb, ei);
        chk("rand_best_sad", best_sad, eb); chk("rand_best_idx", best_idx, ei);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sad_search_controller.md
Name: sad_search_controller

Overview:
- Sequences one 8x8 SAD datapath over NUM_CAND candidate positions of a fractional motion search.
- For each candidate it issues row addresses to the original/candidate pixel buffers. It drives the SAD datapath's enable_calculation, sel, enable_out and lambda_r controls, then reads back the lambda-weighted SAD.
- It keeps the minimum cost across all candidates and reports best cost and best index with a done pulse.
- Sits between the motion-estimation top-level FSM and the SAD datapath.

Parameters:
- DATAWIDTH, 8, pixel width; SAD result width is DATAWIDTH+9, lambda cost width is DATAWIDTH+8.
- NUM_CAND, 9, candidates per search (1..16).
- ROWS, 8, rows per block (8 pixels per row consumed in parallel).

Ports:
- clock  in  1  single clock domain, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a search; sampled only in IDLE.
- flush  in  1  synchronous abort; forces IDLE on the next edge, no done.
- cost_in  in  DATAWIDTH+8  lambda·rate cost for candidate cand_idx, valid combinationally while cand_idx is stable.
- sad_in  in  DATAWIDTH+9  registered SAD output of the datapath.
- cand_idx  out  4  candidate address to the pixel buffer and cost table.
- row_idx  out  3  row address to the pixel buffer (1-cycle read latency).
- sad_enable_calculation  out  1  accumulate strobe to the datapath.
- sad_sel  out  1  1 = accumulator loads lambda_r+row sum (first row); 0 = accumulate.
- sad_enable_out  out  1  datapath output-register load strobe.
- sad_lambda_r  out  DATAWIDTH+8  cost applied by the datapath for the current candidate.
- busy  out  1  high from the cycle after start until done/flush.
- done  out  1  one-cycle pulse, best_* valid.
- best_sad  out  DATAWIDTH+9  minimum cost found.
- best_idx  out  4  index of that minimum.

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0, including best_sad, best_idx, cand_idx, row_idx and sad_lambda_r.
- FSM states: IDLE, FETCH, WAIT, OUT, CAPTURE, DONE.
- IDLE: start=1 at cycle 0 -> FETCH at cycle 1, cand_idx=0, busy=1.
- FETCH: 8 cycles, row_idx 0..7. On the row-0 cycle, cost_in is registered into sad_lambda_r and held for the whole candidate.
- Enables trail the address by one cycle to match buffer latency. sad_enable_calculation is high on the 8 cycles after the addresses are issued; sad_sel=1 only with row 0's enable.
- WAIT: one cycle, the last enable cycle.
- OUT: sad_enable_out=1 for exactly one cycle, the cycle after the last enable.
- CAPTURE: sad_in is valid.
  - For cand 0, load best_sad/best_idx unconditionally.
  - Otherwise replace only if sad_in < best_sad (strict), so ties keep the lower index.
- After CAPTURE: if cand_idx==NUM_CAND-1 go to DONE; else increment cand_idx, reset row_idx to 0, go to FETCH.
- Per candidate: 11 cycles. Candidate k's FETCH starts at cycle 1+11k; its CAPTURE is at cycle 11+11k.
- DONE: done=1 for one cycle at cycle 11·NUM_CAND+1 (100 for 9); busy=0 in the same cycle; return to IDLE.
- best_* hold until the next search's cand-0 capture.
- start while busy: ignored. start in the DONE cycle: ignored.
- flush: highest priority after reset.
  - Next state IDLE, all strobes 0 immediately on that edge, busy=0.
  - best_* are not updated by the aborted search; they retain previous values.
- Unsigned comparisons only; no saturation. Datapath widths already guarantee no overflow.

Decomposition:
- Shared package: state encoding enum and constants ROW_LAST=ROWS-1, CYCLES_PER_CAND=ROWS+3, SAD_W=DATAWIDTH+9, COST_W=DATAWIDTH+8.
- One natural sub-module, sad_min_tracker: holds best_sad/best_idx, with load-first / strict-less update on a capture strobe.

Test Plan:
1. NUM_CAND=9, all pixel diffs 0, costs {50,40,30,20,10,20,30,40,50} -> best_sad=10, best_idx=4, done at cycle 100, exactly one pulse.
2. Cost table all 100 (tie), zero diffs -> best_idx=0, best_sad=100. Enable trace per candidate is exactly 8 enables, sel only on the first, one enable_out.
3. Diff 1 per pixel on cand 7 only, others diff 3, costs 0 -> best_sad=64, best_idx=7.
4. start pulsed again at cycles 5 and 100 -> ignored; exactly one done; busy stays continuously 1 for cycles 1..99.
5. flush at cycle 40 (mid cand 3) -> IDLE at 41, no done, best_* equal prior search's values; new start completes normally.
6. reset low at cycle 57 for 2 cycles -> all outputs 0 immediately (async); after release, start yields correct result at start+100.
